// File: rtl/rv_reg_file.sv
// RISC-V integer register file: two combinational read ports, one write port, pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward the writeback value and clear busy in the writeback cycle.
module rv_reg_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic            wr_en;
  logic            iss_en;

  assign wr_en  = we && (rd_addr != '0);
  assign iss_en = iss_valid && (iss_rd != '0);

  // x0 is never written, so it keeps its reset value of zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Clear applied before set so a same-index issue keeps the bit pending
  always_comb begin
    pend_nxt = pend;
    if (wr_en) begin
      pend_nxt[rd_addr] = 1'b0;
    end
    if (iss_en) begin
      pend_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Combinational read ports
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    rs1_busy = (rs1_addr == '0) ? 1'b0 : pend[rs1_addr];
    rs2_busy = (rs2_addr == '0) ? 1'b0 : pend[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (rst && wr_en && (rd_addr == rs1_addr)) begin
      rs1_data = rd_data;
      rs1_busy = iss_valid && (iss_rd == rs1_addr);
    end
    if (rst && wr_en && (rd_addr == rs2_addr)) begin
      rs2_data = rd_data;
      rs2_busy = iss_valid && (iss_rd == rs2_addr);
    end
`endif
  end

endmodule

// File: tb/tb_rv_reg_file.sv
// Randomised bench for rv_reg_file against an array-based reference model, plus directed literal checks.
module tb_rv_reg_file;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, iss_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, rd_data;
  logic            rs1_busy, rs2_busy, we, iss_valid;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] mregs [NREG];
  logic            mpend [NREG];

  rv_reg_file #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain arrays
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mregs[i] = '0;
        mpend[i] = 1'b0;
      end
    end else begin
      if (we && rd_addr != 0) begin
        mregs[rd_addr] = rd_data;
        mpend[rd_addr] = 1'b0;
      end
      if (iss_valid && iss_rd != 0) mpend[iss_rd] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst && we && rd_addr != 0 && rd_addr == a) return rd_data;
`endif
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rst && we && rd_addr != 0 && rd_addr == a) return iss_valid && iss_rd == a;
`endif
    return mpend[a];
  endfunction

  always @(negedge clk) begin
    chk("rs1_data", rs1_data, exp_data(rs1_addr));
    chk("rs2_data", rs2_data, exp_data(rs2_addr));
    chk("rs1_busy", XLEN'(rs1_busy), XLEN'(exp_busy(rs1_addr)));
    chk("rs2_busy", XLEN'(rs2_busy), XLEN'(exp_busy(rs2_addr)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; iss_valid = 1'b0;
    rd_addr = '0; rd_data = '0; iss_rd = '0;
    rs1_addr = AW'(5); rs2_addr = AW'(31 % NREG);
    we = 1'b1; rd_addr = AW'(5); rd_data = XLEN'(32'hFFFF_FFFF);
    iss_valid = 1'b1; iss_rd = AW'(5);
    step(); step();
    chk("reset_rs1_data", rs1_data, '0);
    chk("reset_rs2_data", rs2_data, '0);
    chk("reset_rs1_busy", XLEN'(rs1_busy), '0);
    idle();
    rst = 1'b1;
    step();

    we = 1'b1; rd_addr = AW'(7); rd_data = XLEN'(32'hDEADBEEF);
    step(); idle();
    rs1_addr = AW'(7);
    #1 chk("write7_read", rs1_data, XLEN'(32'hDEADBEEF));

    we = 1'b1; rd_addr = '0; rd_data = XLEN'(32'h1234);
    step(); idle();
    rs2_addr = '0;
    #1 chk("x0_read", rs2_data, '0);

    iss_valid = 1'b1; iss_rd = AW'(3);
    step(); idle();
    rs1_addr = AW'(3);
    #1 chk("busy3_set", XLEN'(rs1_busy), XLEN'(1));
    we = 1'b1; rd_addr = AW'(3); rd_data = XLEN'(32'h33);
`ifdef REGFILE_BYPASS_EN
    #1 chk("busy3_wb_cycle", XLEN'(rs1_busy), XLEN'(0));
`else
    #1 chk("busy3_wb_cycle", XLEN'(rs1_busy), XLEN'(1));
`endif
    step(); idle();
    #1 chk("busy3_clear", XLEN'(rs1_busy), XLEN'(0));

    iss_valid = 1'b1; iss_rd = '0;
    step(); idle();
    rs1_addr = '0;
    #1 chk("busy0_never", XLEN'(rs1_busy), XLEN'(0));

    iss_valid = 1'b1; iss_rd = AW'(4);
    we = 1'b1; rd_addr = AW'(4); rd_data = XLEN'(32'h44);
    step(); idle();
    rs1_addr = AW'(4);
    #1 chk("collide_busy", XLEN'(rs1_busy), XLEN'(1));
    chk("collide_data", rs1_data, XLEN'(32'h44));

    iss_valid = 1'b1; iss_rd = AW'(9);
    step(); idle();
    we = 1'b1; rd_addr = AW'(9); rd_data = XLEN'(32'h55); rs1_addr = AW'(9);
`ifdef REGFILE_BYPASS_EN
    #1 chk("bypass_data", rs1_data, XLEN'(32'h55));
    chk("bypass_busy", XLEN'(rs1_busy), XLEN'(0));
`else
    #1 chk("bypass_data", rs1_data, XLEN'(0));
    chk("bypass_busy", XLEN'(rs1_busy), XLEN'(1));
`endif
    step(); idle();

    we = 1'b1; rd_addr = AW'(12); rd_data = XLEN'(32'hA5A5A5A5);
    step(); idle();
    rs1_addr = AW'(12); rs2_addr = AW'(12);
    #1 chk("dual_rs1", rs1_data, XLEN'(32'hA5A5A5A5));
    chk("dual_rs2", rs2_data, XLEN'(32'hA5A5A5A5));

    // Mid-cycle reset after writes and pending issues
    iss_valid = 1'b1; iss_rd = AW'(12);
    step(); idle();
    #2 rst = 1'b0;
    #1 chk("midrst_data1", rs1_data, '0);
    chk("midrst_data2", rs2_data, '0);
    chk("midrst_busy", XLEN'(rs1_busy), '0);
    step();
    rst = 1'b1;
    step();

    for (int n = 0; n < 3000; n++) begin
      we        = ($urandom_range(99) < 50);
      rd_addr   = AW'($urandom_range(NREG - 1));
      rd_data   = XLEN'({$urandom(), $urandom()});
      iss_valid = ($urandom_range(99) < 40);
      iss_rd    = ($urandom_range(9) == 0) ? rd_addr : AW'($urandom_range(NREG - 1));
      rs1_addr  = ($urandom_range(3) == 0) ? rd_addr : AW'($urandom_range(NREG - 1));
      rs2_addr  = ($urandom_range(3) == 0) ? rs1_addr : AW'($urandom_range(NREG - 1));
      if ($urandom_range(199) == 0) begin
        #2 rst = 1'b0;
        #1 chk("rand_rst_data", rs1_data, '0);
        chk("rand_rst_busy", XLEN'(rs2_busy), '0);
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end
    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
